// File: rtl/bht_2slot.sv
// Branch history table: 2-bit saturating direction counters,
// organised as rows of half-word slots, one fetch word per lookup.
module bht_2slot #(
   parameter int unsigned NR_ENTRIES      = 32,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned VLEN            = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       bht_update_valid_i,
   input  logic [VLEN-1:0]            bht_update_pc_i,
   input  logic                       bht_update_taken_i,
   output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
   output logic [INSTR_PER_FETCH-1:0] bht_taken_o
);

   localparam int unsigned ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS  = $clog2(ROWS);
   localparam int unsigned SLOT_BITS = $clog2(INSTR_PER_FETCH);
   localparam int unsigned IDX_BITS  = ROW_BITS + SLOT_BITS;

   logic [NR_ENTRIES-1:0]      valid_q, valid_d;
   logic [NR_ENTRIES-1:0][1:0] cnt_q, cnt_d;

   logic [ROW_BITS-1:0] lkp_row;
   logic [IDX_BITS-1:0] lkp_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic                upd_en;
   logic                unused_bits;

   // Entry index is {row, slot}, i.e. the half-word address bits.
   assign lkp_row = vpc_i[IDX_BITS:SLOT_BITS+1];
   assign upd_idx = bht_update_pc_i[IDX_BITS:1];
   assign upd_en  = bht_update_valid_i & ~debug_mode_i & ~flush_i;

   assign unused_bits = ^{vpc_i[VLEN-1:IDX_BITS+1],
                          vpc_i[SLOT_BITS:0],
                          bht_update_pc_i[VLEN-1:IDX_BITS+1],
                          bht_update_pc_i[0]};

   always_comb begin
      bht_valid_o = '0;
      bht_taken_o = '0;
      lkp_idx     = '0;
      for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
         lkp_idx        = {lkp_row, SLOT_BITS'(i)};
         bht_valid_o[i] = valid_q[lkp_idx];
         bht_taken_o[i] = valid_q[lkp_idx] & cnt_q[lkp_idx][1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         valid_d = '0;
         cnt_d   = '0;
      end else if (upd_en) begin
         if (!valid_q[upd_idx]) begin
            valid_d[upd_idx] = 1'b1;
            cnt_d[upd_idx]   = bht_update_taken_i ? 2'b10 : 2'b01;
         end else if (bht_update_taken_i) begin
            if (cnt_q[upd_idx] != 2'b11)
               cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
         end else begin
            if (cnt_q[upd_idx] != 2'b00)
               cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   a_pow2: assert property (@(posedge clk_i)
      (NR_ENTRIES & (NR_ENTRIES - 1)) == 0);
   a_no_x: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({bht_valid_o, bht_taken_o}));
`endif

endmodule

// File: tb/tb_bht_2slot.sv
// Self-checking bench for bht_2slot: directed scenarios plus
// randomized traffic against a counter-array reference model.
module tb_bht_2slot;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        debug_mode_i = 1'b0;
   logic [31:0] vpc_i = 32'h8000_0000;
   logic        upd_v = 1'b0;
   logic [31:0] upd_pc = 32'h0;
   logic        upd_tk = 1'b0;
   logic [1:0]  bht_valid_o;
   logic [1:0]  bht_taken_o;

   int checks = 0;
   int failures = 0;

   bit mval[32];
   int mcnt[32];

   bht_2slot dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .flush_i            (flush_i),
      .debug_mode_i       (debug_mode_i),
      .vpc_i              (vpc_i),
      .bht_update_valid_i (upd_v),
      .bht_update_pc_i    (upd_pc),
      .bht_update_taken_i (upd_tk),
      .bht_valid_o        (bht_valid_o),
      .bht_taken_o        (bht_taken_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void model_clear();
      for (int e = 0; e < 32; e++) begin
         mval[e] = 1'b0;
         mcnt[e] = 0;
      end
   endfunction

   // Counter value 0..3; >=2 means predict taken.
   function automatic void model_update(input logic [31:0] pc, input logic tk);
      int e;
      e = int'(pc[5:1]);
      if (!mval[e]) begin
         mval[e] = 1'b1;
         mcnt[e] = tk ? 2 : 1;
      end else if (tk) begin
         mcnt[e] = (mcnt[e] < 3) ? mcnt[e] + 1 : 3;
      end else begin
         mcnt[e] = (mcnt[e] > 0) ? mcnt[e] - 1 : 0;
      end
   endfunction

   function automatic void model_lookup(input logic [31:0] pc,
                                        output logic [1:0] v,
                                        output logic [1:0] t);
      int e;
      for (int s = 0; s < 2; s++) begin
         e = int'(pc[5:2]) * 2 + s;
         v[s] = mval[e];
         t[s] = mval[e] && (mcnt[e] >= 2);
      end
   endfunction

   // Advance one edge; returns at posedge+1 with the model in step.
   task automatic cycle();
      @(posedge clk_i);
      if (rst_ni) begin
         if (flush_i)
            model_clear();
         else if (upd_v && !debug_mode_i)
            model_update(upd_pc, upd_tk);
      end
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic tk);
      upd_pc = pc;
      upd_tk = tk;
      upd_v  = 1'b1;
      cycle();
      upd_v  = 1'b0;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      vpc_i = 32'h8000_0000;
      #2;
      checks++;
      if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
         $display("FAIL reset_in v=%b t=%b exp 00/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      cycle();
      rst_ni = 1'b1;
      model_clear();
      cycle();
      checks++;
      if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
         $display("FAIL reset_rel v=%b t=%b exp 00/00", bht_valid_o, bht_taken_o);
         failures++;
      end
   endtask

   task automatic test_basic();
      vpc_i = 32'h8000_0004;
      do_update(32'h8000_0004, 1'b1);
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
         $display("FAIL basic_first v=%b t=%b exp 01/01", bht_valid_o, bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0004, 1'b0);
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b00) begin
         $display("FAIL basic_nt1 v=%b t=%b exp 01/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0004, 1'b0);
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b00) begin
         $display("FAIL basic_nt2 v=%b t=%b exp 01/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      // Counter should now be at 0: one taken must stay not-taken.
      do_update(32'h8000_0004, 1'b1);
      checks++;
      if (bht_taken_o !== 2'b00) begin
         $display("FAIL basic_floor t=%b exp 00", bht_taken_o);
         failures++;
      end
   endtask

   task automatic test_saturation();
      vpc_i = 32'h8000_0008;
      for (int k = 0; k < 5; k++) do_update(32'h8000_0008, 1'b1);
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
         $display("FAIL sat_hi v=%b t=%b exp 01/01", bht_valid_o, bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0008, 1'b0);
      checks++;
      if (bht_taken_o !== 2'b01) begin
         $display("FAIL sat_hi_nt t=%b exp 01", bht_taken_o);
         failures++;
      end
      for (int k = 0; k < 3; k++) do_update(32'h8000_0008, 1'b0);
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b00) begin
         $display("FAIL sat_lo v=%b t=%b exp 01/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0008, 1'b0);
      do_update(32'h8000_0008, 1'b1);
      checks++;
      if (bht_taken_o !== 2'b00) begin
         $display("FAIL sat_lo_hold t=%b exp 00", bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0008, 1'b1);
      checks++;
      if (bht_taken_o !== 2'b01) begin
         $display("FAIL sat_climb t=%b exp 01", bht_taken_o);
         failures++;
      end
   endtask

   task automatic test_alias();
      apply_reset();
      vpc_i = 32'h8000_0004;
      do_update(32'h8000_0006, 1'b1);
      checks++;
      if (bht_valid_o !== 2'b10 || bht_taken_o !== 2'b10) begin
         $display("FAIL slot1 v=%b t=%b exp 10/10", bht_valid_o, bht_taken_o);
         failures++;
      end
      do_update(32'h8000_0044, 1'b0);
      checks++;
      if (bht_valid_o !== 2'b11 || bht_taken_o !== 2'b10) begin
         $display("FAIL alias v=%b t=%b exp 11/10", bht_valid_o, bht_taken_o);
         failures++;
      end
      vpc_i = 32'h8000_0000;
      #1;
      checks++;
      if (bht_valid_o !== 2'b00) begin
         $display("FAIL other_row v=%b exp 00", bht_valid_o);
         failures++;
      end
   endtask

   task automatic test_same_cycle();
      vpc_i  = 32'h8000_000C;
      upd_pc = 32'h8000_000C;
      upd_tk = 1'b1;
      upd_v  = 1'b1;
      #1;
      checks++;
      if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
         $display("FAIL same_pre v=%b t=%b exp 00/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      cycle();
      upd_v = 1'b0;
      checks++;
      if (bht_valid_o !== 2'b01 || bht_taken_o !== 2'b01) begin
         $display("FAIL same_post v=%b t=%b exp 01/01", bht_valid_o, bht_taken_o);
         failures++;
      end
   endtask

   task automatic test_flush_debug();
      do_update(32'h8000_0010, 1'b1);
      do_update(32'h8000_003E, 1'b1);
      flush_i = 1'b1;
      do_update(32'h8000_0010, 1'b1);
      flush_i = 1'b0;
      for (int r = 0; r < 16; r++) begin
         vpc_i = 32'h8000_0000 | (r << 2);
         #1;
         checks++;
         if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
            $display("FAIL flush_row%0d v=%b t=%b exp 00/00", r, bht_valid_o, bht_taken_o);
            failures++;
         end
      end
      vpc_i = 32'h8000_0010;
      debug_mode_i = 1'b1;
      do_update(32'h8000_0010, 1'b1);
      #1;
      checks++;
      if (bht_valid_o !== 2'b00) begin
         $display("FAIL debug_drop v=%b exp 00", bht_valid_o);
         failures++;
      end
      debug_mode_i = 1'b0;
      do_update(32'h8000_0010, 1'b1);
      debug_mode_i = 1'b1;
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      debug_mode_i = 1'b0;
      checks++;
      if (bht_valid_o !== 2'b00) begin
         $display("FAIL debug_flush v=%b exp 00", bht_valid_o);
         failures++;
      end
   endtask

   task automatic test_async_reset();
      do_update(32'h8000_0020, 1'b1);
      do_update(32'h8000_0022, 1'b1);
      vpc_i = 32'h8000_0020;
      #2;
      checks++;
      if (bht_valid_o !== 2'b11 || bht_taken_o !== 2'b11) begin
         $display("FAIL pre_rst v=%b t=%b exp 11/11", bht_valid_o, bht_taken_o);
         failures++;
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (bht_valid_o !== 2'b00 || bht_taken_o !== 2'b00) begin
         $display("FAIL async_rst v=%b t=%b exp 00/00", bht_valid_o, bht_taken_o);
         failures++;
      end
      model_clear();
      do_update(32'h8000_0020, 1'b1);
      rst_ni = 1'b1;
      cycle();
      checks++;
      if (bht_valid_o !== 2'b00) begin
         $display("FAIL rst_upd_lost v=%b exp 00", bht_valid_o);
         failures++;
      end
   endtask

   task automatic test_random();
      logic [1:0] ev, et;
      for (int n = 0; n < 400; n++) begin
         vpc_i        = $urandom;
         upd_pc       = (n % 3 == 0) ? vpc_i : $urandom;
         upd_v        = $urandom_range(0, 3) != 0;
         upd_tk       = $urandom_range(0, 2) != 0;
         flush_i      = $urandom_range(0, 39) == 0;
         debug_mode_i = $urandom_range(0, 9) == 0;
         #1;
         model_lookup(vpc_i, ev, et);
         checks++;
         if (bht_valid_o !== ev || bht_taken_o !== et) begin
            $display("FAIL rand%0d pc=%h v=%b t=%b exp %b/%b",
                     n, vpc_i, bht_valid_o, bht_taken_o, ev, et);
            failures++;
         end
         cycle();
      end
      upd_v = 1'b0;
      flush_i = 1'b0;
      debug_mode_i = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_flush_debug();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bht_2slot.md
Name: bht_2slot

Overview:
- Branch history table for the cv32a65x frontend. Holds BHTEntries (32) two-bit saturating direction counters.
- Organised as rows of two half-word slots, so one fetch word (two RVC slots) is predicted per lookup.
- Sits between the fetch-address generator (lookup side) and the branch unit (resolution/update side).

Parameters:
- NR_ENTRIES, 32, total counters; power of two, at least INSTR_PER_FETCH.
- INSTR_PER_FETCH, 2, slots per row (16-bit granules per 32-bit fetch word).
- VLEN, 32, virtual PC width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  clear all history; synchronous, takes effect at next edge
- debug_mode_i  in  1  core in debug mode; updates suppressed
- vpc_i  in  VLEN  lookup fetch address
- bht_update_valid_i  in  1  resolved conditional branch, update strobe
- bht_update_pc_i  in  VLEN  PC of the resolved branch
- bht_update_taken_i  in  1  resolved direction
- bht_valid_o  out  INSTR_PER_FETCH  per-slot entry valid for the vpc_i row
- bht_taken_o  out  INSTR_PER_FETCH  per-slot predicted taken

Behaviour:
- Geometry:
  - ROWS = NR_ENTRIES/INSTR_PER_FETCH (16).
  - ROW_BITS = log2(ROWS) (4).
  - Row index = pc[ROW_BITS+1:2], i.e. bits [5:2].
  - Slot index = pc[1].
  - Upper PC bits are not stored; aliasing is permitted.
- State: per entry, a valid bit and a 2-bit counter cnt.
- Reset (rst_ni low, asynchronous): all valid=0, all cnt=2'b00.
  - Outputs therefore read 0 on every slot; outputs are combinational from state only.
- Lookup:
  - Combinational, zero latency.
  - bht_valid_o[i] = valid[row(vpc_i)][i].
  - bht_taken_o[i] = valid & cnt[1].
  - Both slots are always driven regardless of vpc_i[1]; the frontend discards slot 0 when fetch starts at the upper half-word.
- Update: sampled at the rising edge when bht_update_valid_i=1 and debug_mode_i=0 and flush_i=0. Applies to row(bht_update_pc_i), slot bht_update_pc_i[1].
  - Entry invalid: cnt <= taken ? 2'b10 : 2'b01; valid <= 1.
  - Entry valid, taken: cnt <= (cnt==2'b11) ? 2'b11 : cnt+1.
  - Entry valid, not taken: cnt <= (cnt==2'b00) ? 2'b00 : cnt-1.
  - Only the addressed entry changes; all other entries hold.
  - Arithmetic is 2-bit and never wraps; saturation is explicit.
- Read/update same cycle, same entry: lookup returns the pre-update value. There is no forwarding; the new value is visible from the next cycle.
- Flush: flush_i=1 at an edge clears all valid bits and sets all cnt to 2'b00. Flush wins over a simultaneous update, which is dropped.
- Debug: with debug_mode_i=1 the update is dropped; lookup still operates. Flush is still honoured in debug.
- Back-to-back updates to the same entry on consecutive cycles each apply in order (read-modify-write on registered state).
- Reset asserted mid-stream: state clears immediately (asynchronously). An update sampled on the edge where rst_ni is low is lost.
- Implementation: flop array, no SRAM macro (cv32a65x is ASIC-targeted with FPGAEn=0).
- Assertions:
  - NR_ENTRIES is a power of two.
  - No X on outputs after reset release.

Test Plan:
- Reset then lookup vpc_i=0x8000_0000 -> bht_valid_o=2'b00, bht_taken_o=2'b00; repeat after releasing rst_ni -> unchanged.
- Update pc=0x8000_0004 taken -> next cycle vpc_i=0x8000_0004: valid=2'b01, taken=2'b01 (cnt=10).
  - Two not-taken updates -> cnt 01 then 00 -> taken=2'b00, valid stays 2'b01.
- Saturation: five taken updates to 0x8000_0008 -> cnt=11; one not-taken -> cnt=10, still taken; three not-taken -> cnt=00; further not-taken holds 00.
- Slot/alias: update 0x8000_0006 taken -> only slot 1 of row 1 valid (valid=2'b10).
  - Then update 0x8000_0044 not-taken (same row 1, slot 0, alias) -> lookup 0x8000_0004 shows valid=2'b11, taken=2'b10.
- Same-cycle read/update: lookup 0x8000_000C while updating it taken from invalid -> valid=0 that cycle, valid=1/taken=1 next cycle.
- Flush and debug:
  - flush_i=1 together with an update to 0x8000_0010 -> next cycle every row reads 2'b00.
  - With debug_mode_i=1, an update to 0x8000_0010 -> still invalid.
  - Async reset pulse mid-sequence clears a populated table within the same cycle.
